// File: rtl/reg_bank_arbiter_pkg.sv
`default_nettype none
// reg_bank_arbiter_pkg: shared types and constants for the two-requester register bank.
// Rev 1.0
package reg_bank_arbiter_pkg;

  localparam int REGCOUNT_DEFAULT = 4;
  localparam int ADDR_W           = 5;
  localparam int DATA_W           = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACCESS_I2C  = 2'd1,
    ACCESS_HOST = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I2C  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int regcount);
    return (int'(addr) < regcount);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_storage.sv
`default_nettype none
// reg_bank_storage: REGCOUNT x 8-bit register file, one shared read/write index, packed view.
// Rev 1.0
module reg_bank_storage
  import reg_bank_arbiter_pkg::*;
#(
  parameter int REGCOUNT = REGCOUNT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [8*REGCOUNT-1:0] registers_packed_o
);

  logic [DATA_W-1:0] mem_q [REGCOUNT];

  for (genvar k = 0; k < REGCOUNT; k++) begin : g_reg
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        mem_q[k] <= '0;
      end else if (we_i && (addr_i == ADDR_W'(k))) begin
        mem_q[k] <= wdata_i;
      end
    end

    assign registers_packed_o[8*k +: 8] = mem_q[k];
  end

  // Indices with no backing register read as zero.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < REGCOUNT; k++) begin
      if (addr_i == ADDR_W'(k)) begin
        rdata_o = mem_q[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// reg_bank_arbiter: round-robin arbitration of I2C and host accesses to a shared register bank.
// Rev 1.0
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int REGCOUNT = REGCOUNT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i2c_req,
  input  logic                  i2c_we,
  input  logic [ADDR_W-1:0]     i2c_addr,
  input  logic [DATA_W-1:0]     i2c_wdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic                  i2c_ack,
  output logic                  host_ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic [8*REGCOUNT-1:0] registers_packed
);

  arb_state_e        state_q, state_d;
  req_id_e           last_q, last_d;
  cmd_t              cmd_q, cmd_d;
  logic              in_range;
  logic              wr_en;
  logic [DATA_W-1:0] stor_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= REQ_HOST;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
    end
  end

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: begin
        if (i2c_req && (!host_req || (last_q == REQ_HOST))) begin
          state_d     = ACCESS_I2C;
          last_d      = REQ_I2C;
          cmd_d.we    = i2c_we;
          cmd_d.addr  = i2c_addr;
          cmd_d.wdata = i2c_wdata;
        end else if (host_req) begin
          state_d     = ACCESS_HOST;
          last_d      = REQ_HOST;
          cmd_d.we    = host_we;
          cmd_d.addr  = host_addr;
          cmd_d.wdata = host_wdata;
        end
      end
      ACCESS_I2C, ACCESS_HOST: state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  assign in_range = addr_in_range(cmd_q.addr, REGCOUNT);

  // rdata comes from the pre-edge register contents, so a write returns the old value.
  always_comb begin
    i2c_ack  = 1'b0;
    host_ack = 1'b0;
    err      = 1'b0;
    rdata    = '0;
    wr_en    = 1'b0;
    if ((state_q == ACCESS_I2C) || (state_q == ACCESS_HOST)) begin
      i2c_ack  = (state_q == ACCESS_I2C);
      host_ack = (state_q == ACCESS_HOST);
      err      = !in_range;
      rdata    = in_range ? stor_rdata : '0;
      wr_en    = cmd_q.we && in_range;
    end
  end

  reg_bank_storage #(
    .REGCOUNT(REGCOUNT)
  ) u_storage (
    .clock              (clock),
    .reset_n            (reset_n),
    .we_i               (wr_en),
    .addr_i             (cmd_q.addr),
    .wdata_i            (cmd_q.wdata),
    .rdata_o            (stor_rdata),
    .registers_packed_o (registers_packed)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// tb_reg_bank_arbiter: directed and randomized checks of reg_bank_arbiter against a transaction model.
module tb_reg_bank_arbiter;

  localparam int RC    = 4;
  localparam int NRAND = 120;

  logic          clock;
  logic          reset_n;
  logic          i2c_req, i2c_we, host_req, host_we;
  logic [4:0]    i2c_addr, host_addr;
  logic [7:0]    i2c_wdata, host_wdata;
  logic          i2c_ack, host_ack, err;
  logic [7:0]    rdata;
  logic [8*RC-1:0] registers_packed;

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_log[$];

  int         lat_a, lat_b;
  logic [7:0] rd_a, rd_b;
  logic       er_a, er_b;

  reg_bank_arbiter #(.REGCOUNT(RC)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .i2c_req          (i2c_req),
    .i2c_we           (i2c_we),
    .i2c_addr         (i2c_addr),
    .i2c_wdata        (i2c_wdata),
    .host_req         (host_req),
    .host_we          (host_we),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .i2c_ack          (i2c_ack),
    .host_ack         (host_ack),
    .rdata            (rdata),
    .err              (err),
    .registers_packed (registers_packed)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Transaction-level model: a granted access occupies the cycle after its sampling edge.
  logic [7:0]      m_regs [32];
  bit              m_last_host;
  bit              m_pend;
  bit              m_pend_host;
  logic            m_we;
  logic [4:0]      m_addr;
  logic [7:0]      m_wdata;
  logic            exp_i2c_ack, exp_host_ack, exp_err;
  logic [7:0]      exp_rdata;
  logic [8*RC-1:0] exp_packed;

  task automatic model_outputs();
    bit oob;
    oob          = (int'(m_addr) >= RC);
    exp_i2c_ack  = m_pend && !m_pend_host;
    exp_host_ack = m_pend && m_pend_host;
    exp_err      = m_pend && oob;
    exp_rdata    = (m_pend && !oob) ? m_regs[m_addr] : 8'h00;
    for (int k = 0; k < RC; k++) exp_packed[8*k +: 8] = m_regs[k];
  endtask

  task automatic model_clear();
    for (int k = 0; k < 32; k++) m_regs[k] = 8'h00;
    m_last_host = 1'b1;
    m_pend      = 1'b0;
    m_pend_host = 1'b0;
    m_addr      = 5'd0;
  endtask

  task automatic model_step();
    bit win_host;
    if (m_pend) begin
      if (m_we && (int'(m_addr) < RC)) m_regs[m_addr] = m_wdata;
      m_pend = 1'b0;
    end else if (i2c_req || host_req) begin
      if (i2c_req && host_req) win_host = !m_last_host;
      else                     win_host = host_req;
      m_last_host = win_host;
      m_pend      = 1'b1;
      m_pend_host = win_host;
      m_we        = win_host ? host_we    : i2c_we;
      m_addr      = win_host ? host_addr  : i2c_addr;
      m_wdata     = win_host ? host_wdata : i2c_wdata;
    end
  endtask

  initial begin
    model_clear();
    model_outputs();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_clear();
      else          model_step();
      model_outputs();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      n_cmp++;
      if ({i2c_ack, host_ack, err, rdata} !== {exp_i2c_ack, exp_host_ack, exp_err, exp_rdata}) begin
        n_fail++;
        $display("FAIL outputs t=%0t: i2c_ack/host_ack/err/rdata got %b/%b/%b/%02h required %b/%b/%b/%02h",
                 $time, i2c_ack, host_ack, err, rdata, exp_i2c_ack, exp_host_ack, exp_err, exp_rdata);
      end
      n_cmp++;
      if (registers_packed !== exp_packed) begin
        n_fail++;
        $display("FAIL registers_packed t=%0t: got %h required %h", $time, registers_packed, exp_packed);
      end
      if (i2c_ack === 1'b1)  ack_log.push_back(0);
      if (host_ack === 1'b1) ack_log.push_back(1);
    end
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: time limit reached at t=%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  task automatic drive(input bit host, input logic rq, input logic we, input logic [4:0] a,
                       input logic [7:0] d);
    if (host) begin
      host_req = rq; host_we = we; host_addr = a; host_wdata = d;
    end else begin
      i2c_req = rq; i2c_we = we; i2c_addr = a; i2c_wdata = d;
    end
  endtask

  // lat counts negedges from raising req to the negedge that sees the ack.
  task automatic request(input bit host, input logic we, input logic [4:0] a, input logic [7:0] d,
                         input bit keep, output int lat, output logic [7:0] rd, output logic er);
    bit got;
    got = 1'b0;
    lat = 0;
    rd  = 8'h00;
    er  = 1'b0;
    @(posedge clock);
    #1 drive(host, 1'b1, we, a, d);
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      if (host ? host_ack : i2c_ack) begin
        got = 1'b1;
        rd  = rdata;
        er  = err;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout host=%0d: got no ack required ack within 20 cycles", host);
    end
    if (!keep) begin
      @(posedge clock);
      #1 drive(host, 1'b0, we, a, d);
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    #1 reset_n = 1'b0;
    @(negedge clock);
    check("reset_packed", registers_packed, 32'h0);
    check("reset_outputs", {i2c_ack, host_ack, err, rdata}, 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Single host write.
    request(1'b1, 1'b1, 5'd2, 8'hA5, 1'b0, lat_b, rd_b, er_b);
    check("single_lat", lat_b, 2);
    check("single_rdata", rd_b, 8'h00);
    check("single_err", er_b, 1'b0);
    @(negedge clock);
    check("single_packed", registers_packed, 32'h00A5_0000);

    // Tie straight after reset: I2C first, host two cycles later.
    do_reset();
    fork
      request(1'b0, 1'b1, 5'd0, 8'h11, 1'b0, lat_a, rd_a, er_a);
      request(1'b1, 1'b1, 5'd0, 8'h22, 1'b0, lat_b, rd_b, er_b);
    join
    check("tie_i2c_lat", lat_a, 2);
    check("tie_i2c_rdata", rd_a, 8'h00);
    check("tie_host_lat", lat_b, 4);
    check("tie_host_rdata", rd_b, 8'h11);
    @(negedge clock);
    check("tie_reg0", registers_packed[7:0], 8'h22);

    // Sustained contention with req held across acks.
    ack_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          request(1'b0, 1'b1, 5'(i), 8'(8'h40 + i), (i < 3), lat_a, rd_a, er_a);
          check("contention_i2c_lat", (lat_a <= 4), 1);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          request(1'b1, 1'b1, 5'(j), 8'(8'h80 + j), (j < 3), lat_b, rd_b, er_b);
          check("contention_host_lat", (lat_b <= 4), 1);
        end
      end
    join
    check("contention_count", ack_log.size(), 8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++) check("contention_order", ack_log[i], i % 2);

    // Out-of-range index.
    do_reset();
    request(1'b0, 1'b1, 5'd1, 8'h5C, 1'b0, lat_a, rd_a, er_a);
    request(1'b0, 1'b0, 5'd7, 8'h00, 1'b0, lat_a, rd_a, er_a);
    check("oob_read_lat", lat_a, 2);
    check("oob_read_err", er_a, 1'b1);
    check("oob_read_rdata", rd_a, 8'h00);
    request(1'b0, 1'b1, 5'd7, 8'hFF, 1'b0, lat_a, rd_a, er_a);
    check("oob_write_err", er_a, 1'b1);
    @(negedge clock);
    check("oob_write_packed", registers_packed, 32'h0000_5C00);

    // Reset during ACCESS_HOST of a write.
    do_reset();
    @(posedge clock);
    #1 drive(1'b1, 1'b1, 1'b1, 5'd1, 8'h3C);
    @(posedge clock);
    #1;
    check("rstmid_in_access", host_ack, 1'b1);
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd1, 8'h3C);
    #1;
    check("rstmid_ack_cleared", host_ack, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rstmid_no_ack", {i2c_ack, host_ack}, 2'b00);
    end
    check("rstmid_packed", registers_packed, 32'h0);
    request(1'b0, 1'b0, 5'd1, 8'h00, 1'b0, lat_a, rd_a, er_a);
    check("rstmid_first_lat", lat_a, 2);
    check("rstmid_read_reg1", rd_a, 8'h00);

    // Read-before-write on a preloaded register.
    request(1'b1, 1'b1, 5'd3, 8'h5A, 1'b0, lat_b, rd_b, er_b);
    request(1'b0, 1'b1, 5'd3, 8'h77, 1'b0, lat_a, rd_a, er_a);
    check("rmw_old_value", rd_a, 8'h5A);
    request(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, lat_b, rd_b, er_b);
    check("rmw_new_value", rd_b, 8'h77);
    check("rmw_packed", registers_packed, 32'h7700_0000);

    // Randomized traffic from both sides, scored by the model every cycle.
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          bit kp;
          kp = (i < NRAND - 1) && ($urandom_range(0, 3) == 0);
          request(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom), kp,
                  lat_a, rd_a, er_a);
          check("rand_i2c_lat", (lat_a <= 4), 1);
          if (!kp) repeat ($urandom_range(0, 2)) @(posedge clock);
        end
      end
      begin
        for (int j = 0; j < NRAND; j++) begin
          bit kq;
          kq = (j < NRAND - 1) && ($urandom_range(0, 3) == 0);
          request(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom), kq,
                  lat_b, rd_b, er_b);
          check("rand_host_lat", (lat_b <= 4), 1);
          if (!kq) repeat ($urandom_range(0, 2)) @(posedge clock);
        end
      end
    join

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
